// File: rtl/data_proc_sequencer.sv
// data_proc_sequencer: multi-cycle controller for ARM data-processing instructions.
// Sequences register reads, shifter set-up, ALU op set-up and write-back/flag commit,
// and requests a pipeline flush when R15 is written.
module data_proc_sequencer (
  input  logic        clk,
  input  logic        nReset,
  input  logic        instrValid,
  input  logic [31:0] instr,
  input  logic        condPass,
  output logic        instrReady,
  output logic        busy,
  output logic [3:0]  regReadA,
  output logic [3:0]  regReadB,
  output logic [3:0]  regReadS,
  output logic        useImm,
  output logic [7:0]  immValue,
  output logic [3:0]  immRotate,
  output logic [1:0]  shiftType,
  output logic [4:0]  shiftAmount,
  output logic        shiftFromReg,
  output logic        latchRs,
  output logic [3:0]  aluOp,
  output logic        updateFlags,
  output logic        regWriteEn,
  output logic [3:0]  regWriteAddr,
  output logic        flagWriteEn,
  output logic        restoreCpsr,
  output logic        pipeFlush,
  output logic        undefInstr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RSREAD = 3'd1;
  localparam logic [2:0] OPSET  = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] FLUSH  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic [25:0] instrLat;
  logic        undefPulse;

  logic        accept;
  logic        inIsCmp;
  logic        inIllegal;
  logic        inRegShift;

  logic [3:0]  opcode;
  logic        sBit;
  logic [3:0]  rd;
  logic        isCmp;
  logic        regShift;
  logic        rdIsPc;

  // Decode of the incoming word, used only at the acceptance edge.
  assign accept     = instrValid && (state == IDLE);
  assign inIsCmp    = (instr[24:23] == 2'b10);
  // Compare ops without S, non-data-processing class bits, or the NV condition space.
  assign inIllegal  = (inIsCmp && !instr[20]) || (instr[27:26] != 2'b00) ||
                      (instr[31:28] == 4'hF);
  assign inRegShift = !instr[25] && instr[4];

  // Fields of the latched instruction; all outputs come from this copy.
  assign opcode   = instrLat[24:21];
  assign sBit     = instrLat[20];
  assign rd       = instrLat[15:12];
  assign isCmp    = (opcode[3:2] == 2'b10);
  assign regShift = !instrLat[25] && instrLat[4];
  assign rdIsPc   = (rd == 4'hF);

  // State, latched instruction and undefined-instruction pulse.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      instrLat   <= '0;
      undefPulse <= 1'b0;
    end else begin
      state      <= stateNext;
      undefPulse <= accept && condPass && inIllegal;
      if (accept) begin
        instrLat <= instr[25:0];
      end
    end
  end

  // Next-state sequencing.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept && condPass && !inIllegal) begin
          stateNext = inRegShift ? RSREAD : OPSET;
        end
      end
      RSREAD:  stateNext = OPSET;
      OPSET:   stateNext = WRITE;
      WRITE:   stateNext = (!isCmp && rdIsPc) ? FLUSH : IDLE;
      FLUSH:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath control outputs; enables are decoded from state so reset drops them at once.
  always_comb begin
    instrReady   = (state == IDLE);
    busy         = (state != IDLE);
    regReadA     = instrLat[19:16];
    regReadB     = instrLat[3:0];
    regReadS     = instrLat[11:8];
    useImm       = instrLat[25];
    immValue     = instrLat[7:0];
    immRotate    = instrLat[11:8];
    shiftType    = instrLat[6:5];
    shiftAmount  = instrLat[11:7];
    aluOp        = opcode;
    regWriteAddr = rd;
    shiftFromReg = 1'b0;
    latchRs      = 1'b0;
    updateFlags  = 1'b0;
    regWriteEn   = 1'b0;
    flagWriteEn  = 1'b0;
    restoreCpsr  = 1'b0;
    pipeFlush    = 1'b0;
    undefInstr   = undefPulse;
    case (state)
      RSREAD: begin
        latchRs      = 1'b1;
        shiftFromReg = regShift;
      end
      OPSET: begin
        shiftFromReg = regShift;
        updateFlags  = sBit;
      end
      WRITE: begin
        shiftFromReg = regShift;
        updateFlags  = sBit;
        regWriteEn   = !isCmp;
        flagWriteEn  = sBit && !rdIsPc;
        restoreCpsr  = sBit && rdIsPc;
      end
      FLUSH: begin
        pipeFlush = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_proc_sequencer.sv
// Directed self-checking bench for data_proc_sequencer.
module tb_data_proc_sequencer;

  logic        clk = 1'b0;
  logic        nReset;
  logic        instrValid;
  logic [31:0] instr;
  logic        condPass;
  logic        instrReady, busy, useImm, shiftFromReg, latchRs, updateFlags;
  logic        regWriteEn, flagWriteEn, restoreCpsr, pipeFlush, undefInstr;
  logic [3:0]  regReadA, regReadB, regReadS, immRotate, aluOp, regWriteAddr;
  logic [7:0]  immValue;
  logic [1:0]  shiftType;
  logic [4:0]  shiftAmount;

  int checks = 0;
  int fails  = 0;

  logic [47:0] allOut;
  logic [5:0]  en;
  assign allOut = {regReadA, regReadB, regReadS, useImm, immValue, immRotate, shiftType,
                   shiftAmount, shiftFromReg, latchRs, aluOp, updateFlags, regWriteEn,
                   regWriteAddr, flagWriteEn, restoreCpsr, pipeFlush, undefInstr};
  assign en = {regWriteEn, flagWriteEn, restoreCpsr, pipeFlush, undefInstr, latchRs};

  data_proc_sequencer dut (
    .clk(clk), .nReset(nReset), .instrValid(instrValid), .instr(instr),
    .condPass(condPass), .instrReady(instrReady), .busy(busy), .regReadA(regReadA),
    .regReadB(regReadB), .regReadS(regReadS), .useImm(useImm), .immValue(immValue),
    .immRotate(immRotate), .shiftType(shiftType), .shiftAmount(shiftAmount),
    .shiftFromReg(shiftFromReg), .latchRs(latchRs), .aluOp(aluOp),
    .updateFlags(updateFlags), .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr),
    .flagWriteEn(flagWriteEn), .restoreCpsr(restoreCpsr), .pipeFlush(pipeFlush),
    .undefInstr(undefInstr)
  );

  always #5 clk = ~clk;

  // Present one instruction for exactly one acceptance edge; returns 1ns after edge T.
  task automatic issue(input logic [31:0] w, input logic cp);
    @(negedge clk);
    instr = w; condPass = cp; instrValid = 1'b1;
    @(posedge clk);
    #1 instrValid = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; instrValid = 1'b0; instr = '0; condPass = 1'b0;
    #12;
    checks++;
    if ({instrReady, busy} !== 2'b10) begin
      fails++; $display("FAIL reset_ready: got %b expected 10", {instrReady, busy});
    end
    checks++;
    if (allOut !== 48'h0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", allOut);
    end
    @(negedge clk) nReset = 1'b1;
    @(negedge clk);
    checks++;
    if ({instrReady, busy, allOut} !== {2'b10, 48'h0}) begin
      fails++; $display("FAIL reset_release: got %h expected %h", {instrReady, busy, allOut},
                        {2'b10, 48'h0});
    end
  endtask

  task automatic test_adds();
    issue(32'hE2921005, 1'b1);
    @(negedge clk);
    checks++;
    if ({busy, aluOp, updateFlags, useImm, immValue, regWriteEn} !==
        {1'b1, 4'h4, 1'b1, 1'b1, 8'h05, 1'b0}) begin
      fails++; $display("FAIL adds_opset: got %h expected %h",
                        {busy, aluOp, updateFlags, useImm, immValue, regWriteEn},
                        {1'b1, 4'h4, 1'b1, 1'b1, 8'h05, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({regWriteEn, regWriteAddr, flagWriteEn, restoreCpsr, aluOp} !==
        {1'b1, 4'h1, 1'b1, 1'b0, 4'h4}) begin
      fails++; $display("FAIL adds_write: got %h expected %h",
                        {regWriteEn, regWriteAddr, flagWriteEn, restoreCpsr, aluOp},
                        {1'b1, 4'h1, 1'b1, 1'b0, 4'h4});
    end
    @(negedge clk);
    checks++;
    if ({instrReady, regWriteEn, flagWriteEn, pipeFlush} !== 4'b1000) begin
      fails++; $display("FAIL adds_done: got %b expected 1000",
                        {instrReady, regWriteEn, flagWriteEn, pipeFlush});
    end
  endtask

  task automatic test_cmp();
    issue(32'hE1530004, 1'b1);
    @(negedge clk);
    checks++;
    if ({aluOp, regReadA, regReadB, useImm, shiftFromReg, en} !==
        {4'hA, 4'h3, 4'h4, 1'b0, 1'b0, 6'b0}) begin
      fails++; $display("FAIL cmp_opset: got %h expected %h",
                        {aluOp, regReadA, regReadB, useImm, shiftFromReg, en},
                        {4'hA, 4'h3, 4'h4, 1'b0, 1'b0, 6'b0});
    end
    @(negedge clk);
    checks++;
    if (en !== 6'b010000) begin
      fails++; $display("FAIL cmp_write: got %b expected 010000", en);
    end
    @(negedge clk);
    checks++;
    if ({instrReady, pipeFlush} !== 2'b10) begin
      fails++; $display("FAIL cmp_done: got %b expected 10", {instrReady, pipeFlush});
    end
  endtask

  task automatic test_reg_shift();
    issue(32'hE1A00211, 1'b1);
    @(negedge clk);
    checks++;
    if ({busy, regReadS, latchRs, shiftFromReg, regWriteEn} !== {1'b1, 4'h2, 1'b1, 1'b1, 1'b0})
    begin
      fails++; $display("FAIL rs_rsread: got %h expected %h",
                        {busy, regReadS, latchRs, shiftFromReg, regWriteEn},
                        {1'b1, 4'h2, 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({latchRs, shiftFromReg, aluOp, updateFlags, regReadB, shiftType, en} !==
        {1'b0, 1'b1, 4'hD, 1'b0, 4'h1, 2'b00, 6'b0}) begin
      fails++; $display("FAIL rs_opset: got %h expected %h",
                        {latchRs, shiftFromReg, aluOp, updateFlags, regReadB, shiftType, en},
                        {1'b0, 1'b1, 4'hD, 1'b0, 4'h1, 2'b00, 6'b0});
    end
    @(negedge clk);
    checks++;
    if ({en, regWriteAddr, shiftFromReg} !== {6'b100000, 4'h0, 1'b1}) begin
      fails++; $display("FAIL rs_write: got %h expected %h", {en, regWriteAddr, shiftFromReg},
                        {6'b100000, 4'h0, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({instrReady, shiftFromReg, en} !== {1'b1, 1'b0, 6'b0}) begin
      fails++; $display("FAIL rs_done: got %b expected %b", {instrReady, shiftFromReg, en},
                        {1'b1, 1'b0, 6'b0});
    end
  endtask

  task automatic test_movs_pc();
    issue(32'hE1B0F00E, 1'b1);
    @(negedge clk);
    checks++;
    if ({aluOp, updateFlags, regReadB, en} !== {4'hD, 1'b1, 4'hE, 6'b0}) begin
      fails++; $display("FAIL movs_opset: got %h expected %h", {aluOp, updateFlags, regReadB, en},
                        {4'hD, 1'b1, 4'hE, 6'b0});
    end
    @(negedge clk);
    checks++;
    if ({en, regWriteAddr} !== {6'b101000, 4'hF}) begin
      fails++; $display("FAIL movs_write: got %h expected %h", {en, regWriteAddr},
                        {6'b101000, 4'hF});
    end
    @(negedge clk);
    checks++;
    if ({busy, en} !== {1'b1, 6'b000100}) begin
      fails++; $display("FAIL movs_flush: got %b expected %b", {busy, en}, {1'b1, 6'b000100});
    end
    @(negedge clk);
    checks++;
    if ({instrReady, en} !== {1'b1, 6'b0}) begin
      fails++; $display("FAIL movs_done: got %b expected %b", {instrReady, en}, {1'b1, 6'b0});
    end
  endtask

  task automatic test_cond_fail();
    issue(32'hE2921005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({instrReady, updateFlags, en} !== {1'b1, 1'b0, 6'b0}) begin
        fails++; $display("FAIL cond_skip[%0d]: got %b expected %b", i,
                          {instrReady, updateFlags, en}, {1'b1, 1'b0, 6'b0});
      end
    end
  endtask

  task automatic test_undef();
    issue(32'hE1000000, 1'b1);
    @(negedge clk);
    checks++;
    if ({undefInstr, regWriteEn, flagWriteEn, pipeFlush} !== 4'b1000) begin
      fails++; $display("FAIL undef_pulse: got %b expected 1000",
                        {undefInstr, regWriteEn, flagWriteEn, pipeFlush});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({instrReady, en} !== {1'b1, 6'b0}) begin
        fails++; $display("FAIL undef_after[%0d]: got %b expected %b", i, {instrReady, en},
                          {1'b1, 6'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(32'hE2921005, 1'b1);
    @(negedge clk);
    instr = 32'hE1530004; condPass = 1'b1; instrValid = 1'b1;
    @(negedge clk);
    checks++;
    if ({regWriteAddr, aluOp, regWriteEn} !== {4'h1, 4'h4, 1'b1}) begin
      fails++; $display("FAIL b2b_ignored: got %h expected %h", {regWriteAddr, aluOp, regWriteEn},
                        {4'h1, 4'h4, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({instrReady, aluOp} !== {1'b1, 4'h4}) begin
      fails++; $display("FAIL b2b_ready: got %h expected %h", {instrReady, aluOp}, {1'b1, 4'h4});
    end
    @(negedge clk);
    instrValid = 1'b0;
    checks++;
    if ({busy, aluOp, regReadA} !== {1'b1, 4'hA, 4'h3}) begin
      fails++; $display("FAIL b2b_second: got %h expected %h", {busy, aluOp, regReadA},
                        {1'b1, 4'hA, 4'h3});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (instrReady !== 1'b1) begin
      fails++; $display("FAIL b2b_idle: got %b expected 1", instrReady);
    end
  endtask

  task automatic test_async_reset();
    issue(32'hE2921005, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({regWriteEn, flagWriteEn} !== 2'b11) begin
      fails++; $display("FAIL arst_pre: got %b expected 11", {regWriteEn, flagWriteEn});
    end
    #2 nReset = 1'b0;
    #1;
    checks++;
    if ({regWriteEn, flagWriteEn, updateFlags} !== 3'b000) begin
      fails++; $display("FAIL arst_drop: got %b expected 000",
                        {regWriteEn, flagWriteEn, updateFlags});
    end
    @(negedge clk) nReset = 1'b1;
    @(negedge clk);
    checks++;
    if ({instrReady, busy, allOut} !== {2'b10, 48'h0}) begin
      fails++; $display("FAIL arst_after: got %h expected %h", {instrReady, busy, allOut},
                        {2'b10, 48'h0});
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_cmp();
    test_reg_shift();
    test_movs_pc();
    test_cond_fail();
    test_undef();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_proc_sequencer.md
# data_proc_sequencer

Multi-cycle controller that sequences the shared ALU, barrel shifter and register file for ARM data-processing instructions (AND..MVN, all operand-2 forms). It sits between the decode stage and the execute datapath. It accepts one instruction at a time, drives register read addresses, shifter configuration, `aluOp` and `updateFlags`, then commits the result and flags and requests a pipeline flush when R15 is written. The ALU registers its op decode on the clock edge, so the sequencer holds `aluOp` stable for one set-up cycle before write-back.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `instrValid`  in  1  decode presents a data-processing instruction.
- `instr`  in  32  instruction word (cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], op2[11:0]).
- `condPass`  in  1  condition-unit result for `instr`, valid with `instrValid`.
- `instrReady`  out  1  sequencer idle and accepting.
- `busy`  out  1  inverse of `instrReady`.
- `regReadA`  out  4  Rn address (A bus).
- `regReadB`  out  4  Rm address (shifter input).
- `regReadS`  out  4  Rs address (register shift amount).
- `useImm`  out  1  operand 2 is the rotated 8-bit immediate.
- `immValue`  out  8  immediate byte.
- `immRotate`  out  4  rotate field.
- `shiftType`  out  2  LSL/LSR/ASR/ROR.
- `shiftAmount`  out  5  immediate shift amount.
- `shiftFromReg`  out  1  amount taken from the latched Rs[7:0].
- `latchRs`  out  1  capture the Rs read value into the shifter amount register.
- `aluOp`  out  4  ALU opcode.
- `updateFlags`  out  1  ALU flag update enable.
- `regWriteEn`  out  1  write ALU result to `regWriteAddr`.
- `regWriteAddr`  out  4  Rd.
- `flagWriteEn`  out  1  commit ALU new NZCV to CPSR.
- `restoreCpsr`  out  1  copy SPSR to CPSR (S=1, Rd=15).
- `pipeFlush`  out  1  flush fetch/decode, refetch from R15.
- `undefInstr`  out  1  one-cycle pulse on an illegal encoding.

## Operation
- States: IDLE, RSREAD, OPSET, WRITE, FLUSH. Reset enters IDLE.
- In IDLE, `instrReady`=1. Handshake: acceptance on `instrValid && instrReady` at a rising edge. All fields are latched at acceptance and outputs are driven from the latched copy only.
- Accepted with `condPass`=0: go to IDLE next cycle. No write, flag update or flush (one-cycle skip).
- Opcode 8-11 (TST/TEQ/CMP/CMN) with S=0: pulse `undefInstr` for one cycle, then return to IDLE with no writes.
- `instr[25]`=0 and `instr[4]`=1 (register shift): go to RSREAD.
  - Drive `regReadS`, assert `latchRs`, then go to OPSET.
- All other cases go directly to OPSET.
- OPSET: drive `aluOp`=opcode and `updateFlags`=S, with the operand and shifter outputs stable. Next state is WRITE.
- WRITE: `aluOp` and the operands are held.
  - `regWriteEn`=1 unless opcode is 8-11.
  - `flagWriteEn`=S unless Rd=15.
  - `restoreCpsr`=S&(Rd=15).
  - Next state is FLUSH if `regWriteEn`&(Rd=15), else IDLE.
- FLUSH: `pipeFlush`=1 for one cycle, then IDLE.
- Compare ops with Rd=15 never flush (no write).
- `shiftFromReg` is held at 1 from RSREAD through WRITE for register-shift instructions.

## Timing
- Reset values:
  - `instrReady`=1, `busy`=0.
  - `regWriteEn`, `flagWriteEn`, `restoreCpsr`, `pipeFlush`, `undefInstr`, `latchRs`, `updateFlags`, `useImm` and `shiftFromReg` are 0.
  - `aluOp`, all address, shift and immediate outputs are 0.
- Latency from the acceptance edge T:
  - Immediate or immediate-shift instruction: OPSET at T+1, WRITE at T+2, ready at T+3.
  - Register-shift instruction: one extra cycle.
  - Write to R15: one extra FLUSH cycle.
- Only one write-enable cycle per instruction. Enables are never asserted in IDLE, RSREAD or OPSET.
- `nReset` asserted in any state forces IDLE and deasserts all enables immediately (asynchronously). A partial instruction leaves no register or flag write.
- `instrValid` while busy is ignored. Decode must hold the instruction until `instrReady`.

## Test plan
- Reset release, then `0xE2921005` (ADDS r1,r2,#5) with `condPass`=1 -> OPSET at T+1 with `aluOp`=4, `updateFlags`=1, `useImm`=1, `immValue`=0x05. WRITE at T+2 with `regWriteEn`=1, `regWriteAddr`=1, `flagWriteEn`=1. `instrReady` at T+3.
- `0xE1530004` (CMP r3,r4) -> `aluOp`=0xA, `regReadA`=3, `regReadB`=4, `flagWriteEn`=1 in WRITE, `regWriteEn`=0, no `pipeFlush`.
- `0xE1A00211` (MOV r0,r1,LSL r2) -> RSREAD at T+1 with `regReadS`=2 and `latchRs`=1. OPSET at T+2, WRITE at T+3 with `regWriteAddr`=0 and `flagWriteEn`=0.
- `0xE1B0F00E` (MOVS pc,lr) -> WRITE with `regWriteEn`=1, `regWriteAddr`=15, `restoreCpsr`=1, `flagWriteEn`=0. FLUSH next cycle with `pipeFlush`=1. Ready after 4 cycles.
- ADDS with `condPass`=0 -> back in IDLE at T+1 with no enable ever high. `0xE1000000` (TST, S=0) -> `undefInstr` single pulse, no writes.
- `nReset` low during WRITE of ADDS -> `regWriteEn` and `flagWriteEn` drop without waiting for a clock edge. After release: IDLE with `instrReady`=1 and all outputs at reset values.
